dg0045_rom_fetch: RTL and testbench

Upstream program-store stage for the DG0045 4-bit core. It holds the program bytes, drives the core's PC_MUX select, and samples the multiplexed 5-bit PC_HL bus in two halves to rebuild the 10-bit program counter. It then returns the addressed instruction byte on the core's mainROM input (ui_in). Program bytes are loaded beforehand over a valid/ready byte stream.

---
 rtl/dg0045_pkg.sv | 18 +
 rtl/dg0045_prog_mem.sv | 27 ++
 rtl/dg0045_rom_fetch.sv | 158 +++++++++++++++
 tb/tb_dg0045_rom_fetch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dg0045_pkg.sv
// Shared constants and fetch-state encoding for the DG0045 program-store stage.
package dg0045_pkg;

    localparam logic [7:0] NOP_OPCODE = 8'h00;
    localparam int         PC_W       = 10;
    localparam int         PC_HL_W    = 5;

    typedef enum logic [2:0] {
        IDLE,
        LO_DRV,
        LO_CAP,
        HI_DRV,
        HI_CAP,
        READ,
        UPDATE
    } fetch_state_t;

endpackage

// File: rtl/dg0045_prog_mem.sv
// DEPTH x 8 program store: synchronous write, registered read with one cycle of latency.
module dg0045_prog_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_reg [DEPTH];
    logic [7:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we)
            mem_reg[waddr] <= wdata;
        if (re)
            rdata_reg <= mem_reg[raddr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/dg0045_rom_fetch.sv
// DG0045 program-store stage: byte loader plus the PC_HL sampling / ROM fetch loop.
// Define DG0045_ROM_CHECKSUM_EN to add the load_sum output (mod-256 sum of loaded bytes).
module dg0045_rom_fetch
    import dg0045_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    input  logic               load_start,
    input  logic               load_valid,
    input  logic [7:0]         load_data,
    output logic               load_ready,
    input  logic [PC_HL_W-1:0] pc_hl,
    output logic               pc_mux,
    output logic [7:0]         rom_data,
    output logic [PC_W-1:0]    pc_addr,
`ifdef DG0045_ROM_CHECKSUM_EN
    output logic [7:0]         load_sum,
`endif
    output logic               load_full
);

    localparam int              AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              WPW         = $clog2(DEPTH + 1);
    localparam logic [WPW-1:0]  WPTR_FULL   = WPW'(DEPTH);
    localparam logic [1:0]      SETTLE_LAST = 2'(SETTLE - 1);

    fetch_state_t         state_reg, state_next;
    logic [1:0]           settle_cnt_reg, settle_cnt_next;
    logic [PC_HL_W-1:0]   lo5_reg, lo5_next;
    logic [PC_W-1:0]      pc_addr_reg, pc_addr_next;
    logic [7:0]           rom_data_reg, rom_data_next;
    logic [WPW-1:0]       wptr_reg, wptr_next, wr_ptr;
    logic                 load_accept;
    logic                 mem_we, mem_re;
    logic [7:0]           mem_q;
    logic                 addr_in_range;

    // load_start may revive a full loader, so it overrides the full condition for that beat.
    assign load_full   = (wptr_reg == WPTR_FULL);
    assign load_ready  = ~fetch_en & ~load_full;
    assign load_accept = load_valid & ~fetch_en & (load_start | ~load_full);
    assign wr_ptr      = load_start ? '0 : wptr_reg;
    assign wptr_next   = wr_ptr + WPW'(load_accept);
    assign mem_we      = load_accept & ~rst;

    assign addr_in_range = (32'(pc_addr_reg) < 32'(DEPTH));

    dg0045_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (load_data),
        .re    (mem_re),
        .raddr (pc_addr_reg[AW-1:0]),
        .rdata (mem_q)
    );

    always_comb begin
        state_next      = state_reg;
        settle_cnt_next = settle_cnt_reg;
        lo5_next        = lo5_reg;
        pc_addr_next    = pc_addr_reg;
        rom_data_next   = rom_data_reg;
        mem_re          = 1'b0;
        pc_mux          = (state_reg == HI_DRV) || (state_reg == HI_CAP) || (state_reg == READ);

        if (!fetch_en) begin
            state_next      = IDLE;
            settle_cnt_next = '0;
            rom_data_next   = NOP_OPCODE;
        end else begin
            case (state_reg)
                IDLE: begin
                    rom_data_next = NOP_OPCODE;
                    state_next    = LO_DRV;
                end
                LO_DRV: begin
                    if (settle_cnt_reg == SETTLE_LAST) begin
                        settle_cnt_next = '0;
                        state_next      = LO_CAP;
                    end else begin
                        settle_cnt_next = settle_cnt_reg + 2'd1;
                    end
                end
                LO_CAP: begin
                    lo5_next   = pc_hl;
                    state_next = HI_DRV;
                end
                HI_DRV: begin
                    if (settle_cnt_reg == SETTLE_LAST) begin
                        settle_cnt_next = '0;
                        state_next      = HI_CAP;
                    end else begin
                        settle_cnt_next = settle_cnt_reg + 2'd1;
                    end
                end
                HI_CAP: begin
                    // High half carries {PU[3:0], PL[5]}.
                    pc_addr_next = {pc_hl, lo5_reg};
                    state_next   = READ;
                end
                READ: begin
                    mem_re     = 1'b1;
                    state_next = UPDATE;
                end
                UPDATE: begin
                    rom_data_next = addr_in_range ? mem_q : NOP_OPCODE;
                    state_next    = LO_DRV;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            settle_cnt_reg <= '0;
            lo5_reg        <= '0;
            pc_addr_reg    <= '0;
            rom_data_reg   <= NOP_OPCODE;
            wptr_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            settle_cnt_reg <= settle_cnt_next;
            lo5_reg        <= lo5_next;
            pc_addr_reg    <= pc_addr_next;
            rom_data_reg   <= rom_data_next;
            wptr_reg       <= wptr_next;
        end
    end

    assign rom_data = rom_data_reg;
    assign pc_addr  = pc_addr_reg;

`ifdef DG0045_ROM_CHECKSUM_EN
    logic [7:0] sum_reg, sum_next;

    assign sum_next = (load_start ? 8'h00 : sum_reg) + (load_accept ? load_data : 8'h00);

    always_ff @(posedge clk) begin
        if (rst)
            sum_reg <= 8'h00;
        else
            sum_reg <= sum_next;
    end

    assign load_sum = sum_reg;
`endif

endmodule

// File: tb/tb_dg0045_rom_fetch.sv
// Scoreboard bench for dg0045_rom_fetch: a core PC model drives pc_hl from pc_mux.
module tb_dg0045_rom_fetch;

    localparam int DEPTH = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       fetch_en;
    logic       load_start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic [4:0] pc_hl;
    logic       pc_mux;
    logic [7:0] rom_data;
    logic [9:0] pc_addr;
    logic       load_full;
`ifdef DG0045_ROM_CHECKSUM_EN
    logic [7:0] load_sum;
    logic [7:0] model_sum;
`endif

    logic [9:0] core_pc;
    assign pc_hl = pc_mux ? core_pc[9:5] : core_pc[4:0];

    always #5 clk = ~clk;

    dg0045_rom_fetch #(.DEPTH(DEPTH), .SETTLE(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_en   (fetch_en),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .pc_hl      (pc_hl),
        .pc_mux     (pc_mux),
        .rom_data   (rom_data),
        .pc_addr    (pc_addr),
`ifdef DG0045_ROM_CHECKSUM_EN
        .load_sum   (load_sum),
`endif
        .load_full  (load_full)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] model_mem [DEPTH];
    int         model_wptr;
    logic [7:0] prev_rom;

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
    } exp_t;
    exp_t sb_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; drives one beat for exactly one posedge.
    task automatic load_beat(input logic start, input logic [7:0] d);
        logic acc;
        int   wa;
        load_start = start;
        load_valid = 1'b1;
        load_data  = d;
        check_val("load_ready", load_ready, (!fetch_en && model_wptr < DEPTH));
        @(posedge clk);
        acc = !fetch_en && (start || model_wptr < DEPTH);
        wa  = start ? 0 : model_wptr;
        if (acc) begin
            model_mem[wa] = d;
            model_wptr    = wa + 1;
        end else if (start) begin
            model_wptr = 0;
        end
`ifdef DG0045_ROM_CHECKSUM_EN
        model_sum = (start ? 8'h00 : model_sum) + (acc ? d : 8'h00);
`endif
        @(negedge clk);
        load_start = 1'b0;
        load_valid = 1'b0;
        check_val("load_full", load_full, (model_wptr == DEPTH));
    endtask

    // Called at a negedge in IDLE (start=1) or LO_DRV (start=0); returns at the next LO_DRV negedge.
    task automatic run_fetch(input bit start, input logic [9:0] pc);
        exp_t       e;
        logic [5:0] mux_seq;
        mux_seq = 6'b001100;
        core_pc = pc;
        e.addr  = pc;
        e.data  = (pc < 10'(DEPTH)) ? model_mem[pc[7:0]] : 8'h00;
        sb_q.push_back(e);
        if (start) begin
            fetch_en = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        for (int k = 0; k < 6; k++) begin
            if (k != 4)
                check_val($sformatf("pc_mux[%0d]", k), pc_mux, mux_seq[k]);
            check_val("rom_hold", rom_data, prev_rom);
            @(posedge clk);
            @(negedge clk);
        end
        check_val("sb_depth", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val($sformatf("pc_addr@%0h", e.addr), pc_addr, e.addr);
            check_val($sformatf("rom_data@%0h", e.addr), rom_data, e.data);
            $display("fetch pc=%03h rom_data=%02h expected=%02h", e.addr, rom_data, e.data);
            prev_rom = e.data;
        end
    endtask

    task automatic stop_fetch();
        fetch_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("stop_rom", rom_data, 8'h00);
        check_val("stop_mux", pc_mux, 1'b0);
        prev_rom = 8'h00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        fetch_en   = 1'b0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        core_pc    = 10'h000;
        model_wptr = 0;
        prev_rom   = 8'h00;
`ifdef DG0045_ROM_CHECKSUM_EN
        model_sum  = 8'h00;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_rom", rom_data, 8'h00);
        check_val("rst_mux", pc_mux, 1'b0);
        check_val("rst_pc_addr", pc_addr, 10'h000);
        check_val("rst_ready", load_ready, 1'b1);
        check_val("rst_full", load_full, 1'b0);
`ifdef DG0045_ROM_CHECKSUM_EN
        check_val("rst_sum", load_sum, 8'h00);
`endif
        rst = 1'b0;

        // Short back-to-back load, then fetches including out-of-range addresses.
        load_beat(1'b1, 8'h55);
        load_beat(1'b0, 8'h0C);
        load_beat(1'b0, 8'h80);
        run_fetch(1'b1, 10'h001);
        run_fetch(1'b0, 10'h002);
        run_fetch(1'b0, 10'h000);
        run_fetch(1'b0, 10'h3FF);
        run_fetch(1'b0, 10'h100);
        stop_fetch();

        // Fill to DEPTH, refused 257th beat, then restart with load_start.
        for (int i = 0; i < DEPTH; i++)
            load_beat(i == 0, 8'(i * 37 + 11));
        check_val("full_ready", load_ready, 1'b0);
        load_beat(1'b0, 8'hEE);
        run_fetch(1'b1, 10'h000);
        run_fetch(1'b0, 10'h0FF);
        stop_fetch();
        load_beat(1'b1, 8'hA5);
        check_val("restart_full", load_full, 1'b0);
        load_beat(1'b0, 8'h5A);
        run_fetch(1'b1, 10'h000);
        run_fetch(1'b0, 10'h001);
        run_fetch(1'b0, 10'h002);

        // Drop fetch_en while in HI_CAP.
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_val("hicap_mux", pc_mux, 1'b1);
        fetch_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("abort_rom", rom_data, 8'h00);
        check_val("abort_mux", pc_mux, 1'b0);
        prev_rom = 8'h00;
        @(posedge clk);
        @(negedge clk);
        check_val("idle_rom", rom_data, 8'h00);
        run_fetch(1'b1, 10'h0FF);

        // Reset in the middle of the fetch loop.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("rstf_pc_addr", pc_addr, 10'h000);
        check_val("rstf_rom", rom_data, 8'h00);
        check_val("rstf_mux", pc_mux, 1'b0);
        rst        = 1'b0;
        fetch_en   = 1'b0;
        model_wptr = 0;
        prev_rom   = 8'h00;
`ifdef DG0045_ROM_CHECKSUM_EN
        model_sum  = 8'h00;
`endif
        @(posedge clk);
        @(negedge clk);

        // Checksum, bare load_start, and reset during a load beat.
        load_beat(1'b0, 8'hF0);
        load_beat(1'b0, 8'h20);
        load_beat(1'b0, 8'h01);
`ifdef DG0045_ROM_CHECKSUM_EN
        check_val("sum_3", load_sum, 8'h11);
`endif
        load_start = 1'b1;
        @(posedge clk);
        model_wptr = 0;
`ifdef DG0045_ROM_CHECKSUM_EN
        model_sum  = 8'h00;
`endif
        @(negedge clk);
        load_start = 1'b0;
`ifdef DG0045_ROM_CHECKSUM_EN
        check_val("sum_clear", load_sum, 8'h00);
`endif
        load_beat(1'b0, 8'hF0);
        load_beat(1'b0, 8'h20);
        load_beat(1'b0, 8'h01);
        rst        = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'h99;
        @(posedge clk);
        model_wptr = 0;
`ifdef DG0045_ROM_CHECKSUM_EN
        model_sum  = 8'h00;
`endif
        @(negedge clk);
        rst        = 1'b0;
        load_valid = 1'b0;
        check_val("rstl_full", load_full, 1'b0);
`ifdef DG0045_ROM_CHECKSUM_EN
        check_val("rstl_sum", load_sum, 8'h00);
`endif
        load_beat(1'b0, 8'h77);
        run_fetch(1'b1, 10'h000);
        run_fetch(1'b0, 10'h003);
        stop_fetch();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
